// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : Shared types and helpers for the systolic multiplier front end
//            and drain stages.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Feeder sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_t;

  // Number of cycles the skewed stream occupies for an n x n tile.
  function automatic int stream_len(input int n);
    return 3 * n - 2;
  endfunction

  // Bit position of the least significant bit of a packed lane.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/feeder_operand_bank.sv
`default_nettype none
// ============================================================================
// Module   : feeder_operand_bank
// Brief    : One N x N operand register bank with a single write port and
//            N combinational read ports addressed by (row, col).
// Revision : 1.0 - initial release
// ============================================================================
module feeder_operand_bank
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int IW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_row,
  input  logic [IW-1:0]        wr_col,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [N*IW-1:0]      rd_row,
  input  logic [N*IW-1:0]      rd_col,
  output logic [N*WIDTH-1:0]   rd_data
);

  logic [WIDTH-1:0] mem_q [N][N];
  logic [WIDTH-1:0] mem_d [N][N];

  // Next bank contents: matching on each legal index drops out-of-range writes.
  always_comb begin
    mem_d = mem_q;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (wr_en && (wr_row == IW'(r)) && (wr_col == IW'(c))) begin
          mem_d[r][c] = wr_data;
        end
      end
    end
  end

  // Bank storage, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports: an address outside the bank reads as zero.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N; p++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if ((rd_row[p*IW +: IW] == IW'(r)) && (rd_col[p*IW +: IW] == IW'(c))) begin
            rd_data[lane_lsb(p, WIDTH) +: WIDTH] = mem_q[r][c];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Brief    : Buffers two N x N operand tiles and streams them into the top
//            (A, per column) and left (B, per row) edges of the PE array with
//            a one-cycle-per-lane diagonal skew.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  input  logic                   wr_sel,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [$clog2(N)-1:0]   wr_col,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pe_clear,
  output logic                   pe_enable,
  output logic [N*WIDTH-1:0]     a_edge,
  output logic [N*WIDTH-1:0]     b_edge
);

  localparam int IW     = $clog2(N);
  localparam int CW     = $clog2(3 * N - 1);
  localparam int LAST_T = stream_len(N) - 1;

  feeder_state_t      state_q, state_d;
  logic [CW-1:0]      t_q, t_d;
  logic [N*WIDTH-1:0] a_edge_q, a_edge_d;
  logic [N*WIDTH-1:0] b_edge_q, b_edge_d;

  logic               idle;
  logic [N*IW-1:0]    lane_idx;   // skewed k index per lane
  logic [N*IW-1:0]    lane_id;    // fixed lane number per lane
  logic [N-1:0]       lane_vld;
  logic [N*WIDTH-1:0] a_rd, b_rd;

  assign idle = (state_q == ST_IDLE);

  // Sequencer: next state and step counter.
  always_comb begin
    state_d = state_q;
    t_d     = '0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_STREAM;
      ST_STREAM: begin
        if (t_q == CW'(LAST_T)) state_d = ST_DONE;
        else                    t_d = t_q + CW'(1);
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Skew addressing for the step being loaded: lane l carries k = t - l.
  // A lane j reads A[k][j]; B lane i reads B[i][k], so both share k.
  always_comb begin
    lane_idx = '0;
    lane_id  = '0;
    lane_vld = '0;
    for (int l = 0; l < N; l++) begin
      lane_id[l*IW +: IW] = IW'(l);
      if ((t_d >= CW'(l)) && ((t_d - CW'(l)) < CW'(N))) begin
        lane_idx[l*IW +: IW] = IW'(t_d - CW'(l));
        lane_vld[l]          = 1'b1;
      end
    end
  end

  feeder_operand_bank #(.WIDTH(WIDTH), .N(N), .IW(IW)) u_bank_a (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_valid && idle && !wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (lane_idx),
    .rd_col  (lane_id),
    .rd_data (a_rd)
  );

  feeder_operand_bank #(.WIDTH(WIDTH), .N(N), .IW(IW)) u_bank_b (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_valid && idle && wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (lane_id),
    .rd_col  (lane_idx),
    .rd_data (b_rd)
  );

  // Lane data for the next cycle; forced to zero outside STREAM or off-diagonal.
  always_comb begin
    a_edge_d = '0;
    b_edge_d = '0;
    if (state_d == ST_STREAM) begin
      for (int l = 0; l < N; l++) begin
        if (lane_vld[l]) begin
          a_edge_d[lane_lsb(l, WIDTH) +: WIDTH] = a_rd[lane_lsb(l, WIDTH) +: WIDTH];
          b_edge_d[lane_lsb(l, WIDTH) +: WIDTH] = b_rd[lane_lsb(l, WIDTH) +: WIDTH];
        end
      end
    end
  end

  // State, counter and registered lane outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      a_edge_q <= '0;
      b_edge_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_edge_q <= a_edge_d;
      b_edge_q <= b_edge_d;
    end
  end

  // Control outputs decode the state register; wr_ready is held low while
  // reset is asserted so every output reads zero during reset.
  assign wr_ready  = idle && reset_n;
  assign busy      = !idle;
  assign done      = (state_q == ST_DONE);
  assign pe_clear  = (state_q == ST_CLEAR);
  assign pe_enable = (state_q == ST_STREAM);
  assign a_edge    = a_edge_q;
  assign b_edge    = b_edge_q;

endmodule
`default_nettype wire

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Front-end stage of the systolic multiplier: buffers two N×N operand tiles written over a simple write port, then streams them into the top and left edges of the PE array with the diagonal skew the array needs.
- It drives the array's `a_in` column lanes and `b_in` row lanes, plus the array-wide `enable` and `reset`.
- It reports completion once the last operand pair has reached PE(N-1,N-1).

## Interface
- `WIDTH`, 8, operand width in bits.
- `N`, 4, array dimension (lanes per edge), N ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  write strobe into operand buffers.
- `wr_sel`  in  1  0 selects tile A, 1 selects tile B.
- `wr_row`  in  $clog2(N)  row index.
- `wr_col`  in  $clog2(N)  column index.
- `wr_data`  in  WIDTH  element value.
- `wr_ready`  out  1  high in IDLE only; writes while low are dropped.
- `start`  in  1  single-cycle request to stream the stored tiles.
- `busy`  out  1  high from the cycle after an accepted `start` until the end of the DONE cycle.
- `done`  out  1  one-cycle pulse when streaming completes.
- `pe_clear`  out  1  drives the array's synchronous active-high `reset`.
- `pe_enable`  out  1  drives the array's `enable`.
- `a_edge`  out  N*WIDTH  lane j at bits [j*WIDTH +: WIDTH]; feeds `a_in` of array column j.
- `b_edge`  out  N*WIDTH  lane i at bits [i*WIDTH +: WIDTH]; feeds `b_in` of array row i.

## Operation
- Operand storage: two N×N register banks, A and B.
  - A write with `wr_valid && wr_ready` stores `wr_data` at `[wr_row][wr_col]` of the bank chosen by `wr_sel`.
  - An index ≥ N is ignored.
  - Contents persist across runs; they are cleared only by reset.
- FSM states: IDLE, CLEAR, STREAM, DONE.
  - IDLE → CLEAR on `start`. `start` outside IDLE is ignored.
  - CLEAR → STREAM after one cycle.
  - STREAM lasts exactly 3N-2 cycles. A step counter t runs 0..3N-3, and STREAM → DONE when t = 3N-3.
  - DONE → IDLE after one cycle.
- Lane values during STREAM step t:
  - `a_edge` lane j = A[t-j][j] when 0 ≤ t-j < N, else 0.
  - `b_edge` lane i = B[i][t-i] when 0 ≤ t-i < N, else 0.
- Resulting alignment: PE(i,j) sees A[k][j] and B[i][k] on the same cycle, so after the run its accumulator holds Σk B[i][k]·A[k][j], i.e. (B·A)[i][j].
- Output levels per state:
  - `pe_clear` = 1 only in CLEAR.
  - `pe_enable` = 1 only in STREAM.
  - `done` = 1 only in DONE.
  - `busy` = 1 in CLEAR, STREAM and DONE.
  - `wr_ready` = 1 only in IDLE.
- A write and `start` in the same IDLE cycle: the write is committed, and the run streams the updated value.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: state IDLE, counter 0, banks all 0.
  - All outputs 0 except `wr_ready`, which is 1 once `reset_n` is high.
- `start` sampled at edge E:
  - `pe_clear` high in cycle E+1.
  - `pe_enable` and step t=0 data in cycle E+2.
  - The last step is in cycle E+3N-1.
  - `done` is in cycle E+3N.
  - `wr_ready` returns in cycle E+3N+1.
- Total `busy` length is 3N cycles; N=4 gives 12.
- Lane data changes only on the same edges as `pe_enable`. All lanes are 0 whenever `pe_enable` = 0.
- Reset asserted mid-run: all outputs go to reset values immediately (asynchronously). Banks are cleared and no `done` is issued.
- Counter width: $clog2(3N-1) bits. The counter never wraps, because it is cleared on entering STREAM.

## Structure
- Shared package `systolic_pkg` holds:
  - the FSM state enum `feeder_state_t`;
  - localparam function `stream_len(N)` = 3N-2, shared with the drain/collector stage;
  - the lane-packing helper.
- Sub-module `feeder_operand_bank` holds one N×N bank: write port plus N combinational read ports addressed by (row, col). It is instantiated twice.
- The skew index math and the FSM live in `systolic_skew_feeder`.

## Test plan
1. Reset and idle:
   - Assert `reset_n` = 0 mid-cycle → all outputs 0 at once.
   - Release → `wr_ready` = 1, `busy` = 0, all lanes 0.
2. Lane skew, N=4, with A[r][c] = 16r+c+1 and B[r][c] = 16r+c+101:
   - Step t=0 → `a_edge` = {0,0,0,1}, `b_edge` lane0 = 101, other lanes 0.
   - Step t=3 → a lane3 = 4 and b lane3 = 149.
   - Step t=9 → all lanes 0.
3. Cycle counts: `start` at edge E → `pe_clear` at E+1, `pe_enable` high E+2..E+11, `done` pulse at E+12, `busy` high for exactly 12 cycles.
4. End-to-end with a 4×4 `hpe` array, A = identity, B[i][k] = i+k → after `done`, PE(i,j) `c_out` = i+j.
5. Protocol violations:
   - `start` and a write issued during `busy` → ignored; run timing unchanged and banks unchanged on readback.
   - A write and `start` in the same cycle → the new value appears in the stream.
6. Reset during STREAM at t=5:
   - Outputs drop to 0 asynchronously and no `done` is issued.
   - A fresh load and run afterwards produces the correct results.
